uart_fifo_transceiver: RTL and testbench
========================================

UART_FIFO_TRANSCEIVER -- requirements
Module: uart_fifo_transceiver

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): CLK_FREQ, 100000000, sysclk frequency in Hz.
REQ-002 BAUD, 9600, line rate in bit/s.
REQ-003 DATA_BITS, 8, payload width; legal range 5..8.
REQ-004 FIFO_DEPTH, 16, entries per TX and per RX FIFO; a power of two, 2..256.
REQ-005 The block SHALL have these ports (name, direction, width, meaning): sysclk, in, 1, sole clock, rising edge.
REQ-006 reset, in, 1, asynchronous active-low reset.
REQ-007 rxd, in, 1, serial input, asynchronous to sysclk.
REQ-008 txd, out, 1, serial output, idle high.
REQ-009 tx_data, in, DATA_BITS, byte to enqueue.
REQ-010 tx_wr, in, 1, enqueue strobe, one byte per high cycle.
REQ-011 tx_full, out, 1, TX FIFO full.
REQ-012 rx_data, out, DATA_BITS, head of the RX FIFO (first-word fall-through).
REQ-013 rx_rd, in, 1, dequeue strobe.
REQ-014 rx_empty, out, 1, RX FIFO empty.
REQ-015 err_clr, in, 1, clears all sticky error flags.
REQ-016 frame_err, parity_err, overrun, out, 1 each, sticky error flags.
REQ-017 irq, out, 1, interrupt request, equal to (!rx_empty | frame_err | parity_err | overrun).

Function
REQ-018 The baud generator SHALL emit a one-cycle tick every DIV = CLK_FREQ/(BAUD*16) cycles (integer division), i.e. 16x oversampling; with the defaults DIV = 651 and a bit lasts 10416 cycles.
REQ-019 rxd SHALL pass through a two-flop synchroniser before any use.
REQ-020 The RX FSM SHALL use the states IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE->START SHALL occur on a synchronised falling edge of rxd.
REQ-022 In START, rxd SHALL be sampled at tick 8: if low, go to DATA; if high, treat it as a glitch and return to IDLE without setting any flag.
REQ-023 In DATA, DATA_BITS bits SHALL be sampled LSB first at 16-tick intervals; PARITY is entered only when UART_PARITY_EN is defined.
REQ-024 In STOP, rxd SHALL be sampled once: if high, push the byte; if low, set frame_err, discard the byte, and wait for rxd high before entering IDLE.
REQ-025 When the RX FIFO is full, a completed byte SHALL be dropped, overrun set, and existing entries left intact.
REQ-026 The TX FSM SHALL use the states IDLE, START, DATA, PARITY, STOP.
REQ-027 When the TX FIFO is non-empty in IDLE, the TX FSM SHALL pop one byte and drive the start bit low within 2 cycles.
REQ-028 Each TX bit SHALL last 16 ticks: DATA_BITS bits LSB first, optional parity, one stop bit high; the next byte SHALL be sent back-to-back with no idle gap.
REQ-029 tx_wr while tx_full SHALL be ignored; rx_rd while rx_empty SHALL be ignored.
REQ-030 On a full FIFO, a simultaneous write and read SHALL both take effect; on an empty FIFO, a simultaneous write and read SHALL perform only the write.
REQ-031 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
REQ-032 Flags SHALL update on the cycle after a push or pop.
REQ-033 Sticky flags SHALL clear on err_clr; if a set event and err_clr occur in the same cycle, the set wins.

Reset
REQ-034 While reset is low, the block SHALL hold txd=1, tx_full=0, rx_empty=1, rx_data=0, all error flags 0, and irq=0, with both FSMs in IDLE, the FIFOs empty, and the baud counter at 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately; txd SHALL go high asynchronously, and no partial byte SHALL be pushed.

Configuration
REQ-036 When the macro UART_PARITY_EN is defined, a parameter PARITY_ODD (default 0) SHALL select parity: even when 0, odd when 1.
REQ-037 With UART_PARITY_EN defined, TX SHALL insert the parity bit after the data bits, and RX SHALL check it, setting parity_err on mismatch while still pushing the byte.
REQ-038 Without UART_PARITY_EN, the parity state SHALL be unreachable, no parity bit SHALL be sent or expected, and parity_err SHALL be tied to 0.

Verification (defaults, 100 MHz)
REQ-039 Test: tx_wr one cycle with tx_data=0x2D -> txd low within 2 cycles, then 1,0,1,1,0,1,0,0, then stop high; each bit 10416 +/-1 cycles.
REQ-040 Test: rxd frame 0,1,1,0,0,0,1,0,0,1 at 104167 ns per bit -> rx_empty=0 and rx_data=0x23; after rx_rd, rx_empty=1.
REQ-041 Test: 17 frames received with no reads -> overrun=1; 16 reads return bytes 1..16 in order; err_clr -> overrun=0.
REQ-042 Test: frame with stop bit 0 -> frame_err=1, rx_empty stays 1, irq=1.
REQ-043 Test: UART_PARITY_EN defined, even parity, byte 0x23 sent with parity bit 0 -> parity_err=1 and rx_data=0x23.
REQ-044 Test: reset pulled low at bit 4 of a TX frame holding 3 queued bytes -> txd=1 at once, tx_full=0, and no further start bit after reset releases.

Source files
------------

// File: rtl/uart_fifo_transceiver.sv
// uart_fifo_transceiver: 16x-oversampled UART with TX/RX FIFOs and sticky error flags.
// Defining UART_PARITY_EN adds a parity bit in both directions (PARITY_ODD selects odd).
module uart_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         rd,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic we, re;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign re = rd && !empty;
    // a read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it
    assign we = wr && (!full || re);
    assign dout = empty ? '0 : mem[rp[AW-1:0]];
    always_ff @(posedge clk)
        if (we) mem[wp[AW-1:0]] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (we) wp <= wp + 1'b1;
            if (re) rp <= rp + 1'b1;
        end
endmodule

module uart_fifo_transceiver #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD = 9600,
    parameter int DATA_BITS = 8,
    parameter int FIFO_DEPTH = 16
`ifdef UART_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic                 txd,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_wr,
    output logic                 tx_full,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_rd,
    output logic                 rx_empty,
    input  logic                 err_clr,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 irq
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW = $clog2(DIV + 1);
    localparam int CW = $clog2(DIV * 16);
    localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);
    localparam logic [CW-1:0] BIT_M1 = CW'(DIV * 16 - 1);
    localparam logic [2:0] LAST = 3'(DATA_BITS - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef UART_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    logic [DW-1:0] baud_cnt;
    logic tick;
    assign tick = baud_cnt == DIV_M1;
    always_ff @(posedge sysclk or negedge reset)
        if (!reset) baud_cnt <= '0;
        else baud_cnt <= tick ? '0 : baud_cnt + 1'b1;

    logic [2:0] rx_sync;
    logic rx_s;
    assign rx_s = rx_sync[1];
    always_ff @(posedge sysclk or negedge reset)
        if (!reset) rx_sync <= '1;
        else rx_sync <= {rx_sync[1:0], rxd};

    state_t rx_st, tx_st;
    logic [3:0] rx_tc;
    logic [2:0] rx_bc, tx_bc;
    logic [DATA_BITS-1:0] rx_sh, tx_sh, tx_q;
    logic [CW-1:0] tx_cc;
    logic rx_brk, rx_push, rx_full, tx_empty, tx_pop, tx_done;

    uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(sysclk), .rst_n(reset), .wr(tx_wr), .din(tx_data), .rd(tx_pop),
        .dout(tx_q), .full(tx_full), .empty(tx_empty));
    uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(sysclk), .rst_n(reset), .wr(rx_push), .din(rx_sh), .rd(rx_rd),
        .dout(rx_data), .full(rx_full), .empty(rx_empty));

    assign irq = !rx_empty || frame_err || parity_err || overrun;

`ifndef UART_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // rx_tc counts ticks modulo 16; it is re-zeroed at the start edge and at mid-start
    always_ff @(posedge sysclk or negedge reset)
        if (!reset) begin
            rx_st <= IDLE;
            rx_tc <= '0;
            rx_bc <= '0;
            rx_sh <= '0;
            rx_brk <= 1'b0;
            rx_push <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rx_push <= 1'b0;
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun <= 1'b0;
`ifdef UART_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            if (rx_push && rx_full && !rx_rd) overrun <= 1'b1;
            if (tick) rx_tc <= rx_tc + 1'b1;
            case (rx_st)
                IDLE: if (rx_sync[2] && !rx_s) begin
                    rx_st <= START;
                    rx_tc <= '0;
                end
                START: if (tick && rx_tc == 4'd7) begin
                    rx_tc <= '0;
                    rx_bc <= '0;
                    rx_st <= rx_s ? IDLE : DATA;
                end
                DATA: if (tick && rx_tc == 4'd15) begin
                    rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
                    rx_bc <= rx_bc + 1'b1;
                    if (rx_bc == LAST) rx_st <= AFTER_DATA;
                end
`ifdef UART_PARITY_EN
                PARITY: if (tick && rx_tc == 4'd15) begin
                    if (rx_s != (^rx_sh ^ PARITY_ODD)) parity_err <= 1'b1;
                    rx_st <= STOP;
                end
`endif
                STOP: if (rx_brk) begin
                    if (rx_s) begin
                        rx_brk <= 1'b0;
                        rx_st <= IDLE;
                    end
                end else if (tick && rx_tc == 4'd15) begin
                    if (rx_s) begin
                        rx_push <= 1'b1;
                        rx_st <= IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        rx_brk <= 1'b1;
                    end
                end
                default: rx_st <= IDLE;
            endcase
        end

    // TX times whole bits with its own cycle counter so every bit is exactly 16*DIV cycles
    assign tx_done = tx_cc == BIT_M1;
    assign tx_pop = !tx_empty && (tx_st == IDLE || (tx_st == STOP && tx_done));
`ifdef UART_PARITY_EN
    logic tx_par;
`endif
    always_ff @(posedge sysclk or negedge reset)
        if (!reset) begin
            tx_st <= IDLE;
            tx_cc <= '0;
            tx_bc <= '0;
            tx_sh <= '0;
            txd <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par <= 1'b0;
`endif
        end else begin
            if (tx_st != IDLE) tx_cc <= tx_done ? '0 : tx_cc + 1'b1;
            if (tx_pop) begin
                tx_st <= START;
                txd <= 1'b0;
                tx_sh <= tx_q;
`ifdef UART_PARITY_EN
                tx_par <= ^tx_q ^ PARITY_ODD;
`endif
            end else case (tx_st)
                START: if (tx_done) begin
                    txd <= tx_sh[0];
                    tx_sh <= tx_sh >> 1;
                    tx_bc <= '0;
                    tx_st <= DATA;
                end
                DATA: if (tx_done) begin
`ifdef UART_PARITY_EN
                    txd <= tx_bc == LAST ? tx_par : tx_sh[0];
`else
                    txd <= tx_bc == LAST ? 1'b1 : tx_sh[0];
`endif
                    tx_sh <= tx_sh >> 1;
                    tx_bc <= tx_bc + 1'b1;
                    if (tx_bc == LAST) tx_st <= AFTER_DATA;
                end
                PARITY: if (tx_done) begin
                    txd <= 1'b1;
                    tx_st <= STOP;
                end
                STOP: if (tx_done) tx_st <= IDLE;
                default: tx_st <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// tb_uart_fifo_transceiver: self-checking bench for uart_fifo_transceiver, run with a 64-cycle bit time.
module tb_uart_fifo_transceiver;
    localparam int BITC = 64;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       exp_empty;
        logic [7:0] exp_data;
        logic       exp_fe;
    } rx_vec_t;

    logic clk = 1'b0, reset = 1'b1, rxd_drv = 1'b1, loop = 1'b0;
    logic rxd, txd, tx_wr = 1'b0, tx_full, rx_rd = 1'b0, rx_empty, err_clr = 1'b0;
    logic frame_err, parity_err, overrun, irq;
    logic [7:0] tx_data = 8'h00, rx_data;
    int passed = 0, total = 0;

    assign rxd = loop ? txd : rxd_drv;

    uart_fifo_transceiver #(.CLK_FREQ(1000000), .BAUD(15625), .DATA_BITS(8), .FIFO_DEPTH(16)) dut (
        .sysclk(clk), .reset(reset), .rxd(rxd), .txd(txd), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_full(tx_full), .rx_data(rx_data), .rx_rd(rx_rd), .rx_empty(rx_empty), .err_clr(err_clr),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .irq(irq));

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // line image of one frame, bit 0 first: start, data LSB first, [even parity], stop
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
`ifdef UART_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    task automatic send_bits(input logic [10:0] f);
        for (int k = 0; k < NB; k++) begin
            rxd_drv = f[k];
            cyc(BITC);
        end
        rxd_drv = 1'b1;
    endtask

    initial begin
        rx_vec_t rv[6];
        logic rec[1500];
        logic [10:0] fa, fb;
        logic [7:0] b;
        logic [7:0] q[$];
        logic e;
        logic [31:0] ex;
        int first_low, bad, got, sent, cyc_n;
        rv[0] = '{8'h23, 1'b1, 1'b0, 8'h23, 1'b0};
        rv[1] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0};
        rv[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        rv[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0};
        rv[4] = '{8'h5C, 1'b0, 1'b1, 8'h00, 1'b1};
        rv[5] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b0};

        #2 reset = 1'b0;
        cyc(3);
        chk("rst_txd", txd, 1);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_errs", {frame_err, parity_err, overrun}, 0);
        chk("rst_irq", irq, 0);
        reset = 1'b1;
        cyc(3);
        chk("idle_txd", txd, 1);

        first_low = -1;
        for (int i = 0; i < 1500; i++) begin
            rec[i] = txd;
            if (first_low < 0 && txd == 1'b0) first_low = i;
            tx_wr = (i < 2);
            tx_data = (i == 0) ? 8'h2D : 8'hC3;
            @(negedge clk);
        end
        tx_wr = 1'b0;
        chk("tx_start_within_2", 32'(first_low >= 1 && first_low <= 2), 1);
        if (first_low < 0 || first_low > 60) first_low = 2;
        fa = frame_bits(8'h2D);
        fb = frame_bits(8'hC3);
        for (int k = 0; k < 2 * NB; k++) begin
            e = (k < NB) ? fa[k] : fb[(k >= NB) ? k - NB : 0];
            bad = 0;
            for (int j = 0; j < BITC; j++)
                if (rec[first_low + k * BITC + j] !== e) bad++;
            chk($sformatf("tx_bit%0d_samples_wrong", k), bad, 0);
        end
        chk("tx_idle_after_two", rec[first_low + 2 * NB * BITC], 1);

        foreach (rv[i]) begin
            fa = frame_bits(rv[i].d);
            fa[NB-1] = rv[i].stop;
            send_bits(fa);
            cyc(BITC);
            chk($sformatf("rx%0d_empty", i), rx_empty, rv[i].exp_empty);
            chk($sformatf("rx%0d_data", i), rx_data, rv[i].exp_data);
            chk($sformatf("rx%0d_frame_err", i), frame_err, rv[i].exp_fe);
            chk($sformatf("rx%0d_irq", i), irq, !rv[i].exp_empty || rv[i].exp_fe);
            rx_rd = 1'b1;
            err_clr = 1'b1;
            cyc(1);
            rx_rd = 1'b0;
            err_clr = 1'b0;
            cyc(1);
            chk($sformatf("rx%0d_empty_after", i), rx_empty, 1);
            chk($sformatf("rx%0d_irq_after", i), irq, 0);
        end

        rxd_drv = 1'b0;
        cyc(10);
        rxd_drv = 1'b1;
        cyc(4 * BITC);
        chk("glitch_empty", rx_empty, 1);
        chk("glitch_frame_err", frame_err, 0);

        for (int i = 1; i <= 17; i++) send_bits(frame_bits(8'(i)));
        cyc(BITC);
        chk("ovr_flag", overrun, 1);
        chk("ovr_frame_err", frame_err, 0);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("ovr_read%0d", i), rx_data, i);
            rx_rd = 1'b1;
            cyc(1);
            rx_rd = 1'b0;
        end
        chk("ovr_drained", rx_empty, 1);
        chk("ovr_sticky", overrun, 1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(1);
        chk("ovr_cleared", overrun, 0);
        chk("ovr_irq_clear", irq, 0);

`ifdef UART_PARITY_EN
        fa = frame_bits(8'h23);
        fa[9] = ~fa[9];
        send_bits(fa);
        cyc(BITC);
        chk("par_err", parity_err, 1);
        chk("par_data", rx_data, 8'h23);
        chk("par_empty", rx_empty, 0);
        rx_rd = 1'b1;
        err_clr = 1'b1;
        cyc(1);
        rx_rd = 1'b0;
        err_clr = 1'b0;
        cyc(1);
        chk("par_cleared", parity_err, 0);
`endif

        loop = 1'b1;
        cyc(2);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            tx_data = b;
            tx_wr = 1'b1;
            cyc(1);
        end
        tx_wr = 1'b0;
        chk("tx_full_burst", tx_full, 1);
        tx_data = 8'hEE;
        tx_wr = 1'b1;
        cyc(1);
        tx_wr = 1'b0;
        got = 0;
        sent = 0;
        cyc_n = 0;
        while (got < 25 && cyc_n < 30000) begin
            rx_rd = 1'b0;
            tx_wr = 1'b0;
            if (!rx_empty) begin
                ex = (q.size() > 0) ? 32'(q.pop_front()) : 32'hFFFF_FFFF;
                chk($sformatf("loop_rx%0d", got), rx_data, ex);
                rx_rd = 1'b1;
                got++;
            end
            if (sent < 8 && !tx_full && $urandom_range(0, 3) == 0) begin
                b = 8'($urandom);
                q.push_back(b);
                tx_data = b;
                tx_wr = 1'b1;
                sent++;
            end
            cyc(1);
            cyc_n++;
        end
        rx_rd = 1'b0;
        tx_wr = 1'b0;
        chk("loop_count", got, 25);
        bad = 0;
        for (int i = 0; i < 2 * NB * BITC; i++) begin
            if (!rx_empty) bad++;
            cyc(1);
        end
        chk("loop_no_extra", bad, 0);
        chk("loop_errs", {frame_err, parity_err, overrun}, 0);
        loop = 1'b0;

        tx_data = 8'h11;
        tx_wr = 1'b1;
        cyc(1);
        tx_data = 8'h22;
        cyc(1);
        tx_data = 8'h33;
        cyc(1);
        tx_wr = 1'b0;
        cyc_n = 0;
        while (txd && cyc_n < 100) begin
            cyc(1);
            cyc_n++;
        end
        chk("rst_tx_started", txd, 0);
        cyc(4 * BITC + BITC / 2);
        chk("rst_pre_txd_bit4", txd, 0);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_txd", txd, 1);
        chk("rst_mid_tx_full", tx_full, 0);
        chk("rst_mid_rx_empty", rx_empty, 1);
        cyc(3);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 3 * NB * BITC; i++) begin
            if (!txd) bad++;
            cyc(1);
        end
        chk("rst_no_restart", bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
